// File: rtl/circuito_jogo_base.sv
// Base memory game: the player repeats 16 fixed one-hot moves from an internal ROM.
// Contains the control FSM, edge detector, move register, address counter, ROM, comparator and 7-seg debug.
module circuito_jogo_base (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       acertou,
    output logic       errou,
    output logic       pronto,
    output logic [3:0] leds,
    output logic       db_igual,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogadafeita,
    output logic       db_clock,
    output logic       db_iniciar,
    output logic       db_tem_jogada
);

    // Encodings double as the state code shown on db_estado.
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROXIMA     = 4'h6,
        FIM_ACERTOU = 4'hA,
        FIM_ERROU   = 4'hE
    } estado_t;

    estado_t    estado;
    logic [3:0] endereco;
    logic [3:0] jogada_reg;
    logic [3:0] memoria;
    logic       tem_jogada;
    logic       tem_jogada_q;
    logic       jogada;

    // Active-low gfedcba segments for hex digits 0-F.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        // NOTE: a default on every path keeps this purely combinational (no latch).
        memoria = 4'h0;
        case (endereco)
            4'h0: memoria = 4'h1;
            4'h1: memoria = 4'h2;
            4'h2: memoria = 4'h4;
            4'h3: memoria = 4'h8;
            4'h4: memoria = 4'h4;
            4'h5: memoria = 4'h2;
            4'h6: memoria = 4'h1;
            4'h7: memoria = 4'h1;
            4'h8: memoria = 4'h2;
            4'h9: memoria = 4'h2;
            4'hA: memoria = 4'h4;
            4'hB: memoria = 4'h4;
            4'hC: memoria = 4'h8;
            4'hD: memoria = 4'h8;
            4'hE: memoria = 4'h1;
            4'hF: memoria = 4'h4;
            default: memoria = 4'h0;
        endcase
    end

    assign tem_jogada = |chaves;
    assign jogada     = tem_jogada & ~tem_jogada_q;
    assign db_igual   = (jogada_reg == memoria);

    // Flags are set together with the transition into FIM_*, so they match a Moore decode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= INICIAL;
            endereco     <= 4'h0;
            jogada_reg   <= 4'h0;
            tem_jogada_q <= 1'b0;
            acertou      <= 1'b0;
            errou        <= 1'b0;
            pronto       <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values.
            tem_jogada_q <= tem_jogada;
            acertou      <= 1'b0;
            errou        <= 1'b0;
            pronto       <= 1'b0;
            case (estado)
                INICIAL: if (iniciar) estado <= PREPARACAO;
                PREPARACAO: begin
                    endereco   <= 4'h0;
                    jogada_reg <= 4'h0;
                    estado     <= ESPERA;
                end
                ESPERA: if (jogada) estado <= REGISTRA;
                REGISTRA: begin
                    jogada_reg <= chaves;
                    estado     <= COMPARA;
                end
                COMPARA: begin
                    if (!db_igual) begin
                        estado <= FIM_ERROU;
                        errou  <= 1'b1;
                        pronto <= 1'b1;
                    end else if (endereco == 4'hF) begin
                        estado  <= FIM_ACERTOU;
                        acertou <= 1'b1;
                        pronto  <= 1'b1;
                    end else begin
                        estado <= PROXIMA;
                    end
                end
                PROXIMA: begin
                    endereco <= endereco + 4'd1;
                    estado   <= ESPERA;
                end
                FIM_ACERTOU: begin
                    if (iniciar) estado <= PREPARACAO;
                    else begin
                        acertou <= 1'b1;
                        pronto  <= 1'b1;
                    end
                end
                FIM_ERROU: begin
                    if (iniciar) estado <= PREPARACAO;
                    else begin
                        errou  <= 1'b1;
                        pronto <= 1'b1;
                    end
                end
                default: estado <= INICIAL;
            endcase
        end
    end

    assign leds           = jogada_reg;
    assign db_contagem    = hex7(endereco);
    assign db_memoria     = hex7(memoria);
    assign db_estado      = hex7(estado);
    assign db_jogadafeita = hex7(jogada_reg);
    assign db_clock       = clock;
    assign db_iniciar     = iniciar;
    assign db_tem_jogada  = jogada;

endmodule

// File: tb/tb_circuito_jogo_base.sv
// Self-checking bench for circuito_jogo_base: a game-level model is compared every cycle,
// plus directed scenarios with hand-computed literals.
module tb_circuito_jogo_base;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] chaves;
    logic       acertou, errou, pronto, db_igual, db_clock, db_iniciar, db_tem_jogada;
    logic [3:0] leds;
    logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita;

    circuito_jogo_base dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .acertou(acertou), .errou(errou), .pronto(pronto), .leds(leds),
        .db_igual(db_igual), .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_estado(db_estado), .db_jogadafeita(db_jogadafeita), .db_clock(db_clock),
        .db_iniciar(db_iniciar), .db_tem_jogada(db_tem_jogada)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    // Seven-segment patterns (active-low gfedcba) for 0-F.
    function automatic logic [6:0] seg(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[v];
    endfunction

    function automatic logic [3:0] rom(input logic [3:0] a);
        logic [3:0] r [16];
        r = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
              4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};
        return r[a];
    endfunction

    // Game-level model: where the player is in the round and what has been recorded.
    typedef enum {G_IDLE, G_PREP, G_WAIT, G_REG, G_CMP, G_NEXT, G_WON, G_LOST} phase_t;
    phase_t     phase  = G_IDLE;
    logic [3:0] m_idx  = 0;
    logic [3:0] m_move = 0;
    bit         m_prev = 0;

    function automatic logic [3:0] phase_code(input phase_t p);
        case (p)
            G_IDLE: return 4'h0;
            G_PREP: return 4'h1;
            G_WAIT: return 4'h2;
            G_REG:  return 4'h4;
            G_CMP:  return 4'h5;
            G_NEXT: return 4'h6;
            G_WON:  return 4'hA;
            default: return 4'hE;
        endcase
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase  = G_IDLE;
            m_idx  = 0;
            m_move = 0;
            m_prev = 0;
        end else begin
            bit pulse;
            pulse  = (chaves != 0) && !m_prev;
            m_prev = (chaves != 0);
            case (phase)
                G_IDLE: if (iniciar) phase = G_PREP;
                G_PREP: begin m_idx = 0; m_move = 0; phase = G_WAIT; end
                G_WAIT: if (pulse) phase = G_REG;
                G_REG:  begin m_move = chaves; phase = G_CMP; end
                G_CMP:  phase = (m_move != rom(m_idx)) ? G_LOST : (m_idx == 15) ? G_WON : G_NEXT;
                G_NEXT: begin m_idx = m_idx + 1; phase = G_WAIT; end
                G_WON, G_LOST: if (iniciar) phase = G_PREP;
                default: phase = G_IDLE;
            endcase
        end
    end

    always @(negedge clock) begin
        if (cmp_en && reset) begin
            check("estado",      db_estado,      seg(phase_code(phase)));
            check("contagem",    db_contagem,    seg(m_idx));
            check("memoria",     db_memoria,     seg(rom(m_idx)));
            check("jogadafeita", db_jogadafeita, seg(m_move));
            check("leds",        leds,           m_move);
            check("igual",       db_igual,       m_move == rom(m_idx));
            check("acertou",     acertou,        phase == G_WON);
            check("errou",       errou,          phase == G_LOST);
            check("pronto",      pronto,         phase == G_WON || phase == G_LOST);
            check("tem_jogada",  db_tem_jogada,  (chaves != 0) && !m_prev);
            check("db_iniciar",  db_iniciar,     iniciar);
            check("db_clock",    db_clock,       clock);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Hold a move for 10 cycles, release for 10; reports how many pulses were seen.
    task automatic play_move(input logic [3:0] m, output int pulses);
        pulses = 0;
        chaves = m;
        repeat (10) begin
            @(negedge clock);
            if (db_tem_jogada) pulses++;
            step();
        end
        chaves = 4'h0;
        repeat (10) step();
    endtask

    task automatic restart();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        step();
        step();
    endtask

    initial begin
        logic [3:0] seq [16];
        int p;
        int idle_pulses;
        seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

        reset = 1'b1; iniciar = 1'b0; chaves = 4'h0;
        #2 reset = 1'b0;
        repeat (3) step();
        reset  = 1'b1;
        cmp_en = 1;

        check("rst_estado",  db_estado,   7'h40);
        check("rst_pronto",  pronto,      1'b0);
        check("rst_leds",    leds,        4'h0);
        repeat (5) step();
        check("idle_estado", db_estado,   7'h40);

        iniciar = 1'b1;
        repeat (5) step();
        iniciar = 1'b0;
        check("espera_estado",   db_estado,   7'h24);
        check("espera_contagem", db_contagem, 7'h40);

        idle_pulses = 0;
        repeat (100) begin
            @(negedge clock);
            if (db_tem_jogada) idle_pulses++;
            step();
        end
        check("idle_no_pulse",   idle_pulses, 0);
        check("idle_still_wait", db_estado,   7'h24);

        for (int i = 0; i < 16; i++) begin
            play_move(seq[i], p);
            check("pulse_once", p, 1);
            if (i == 0) check("count_step1", db_contagem, 7'h79);
        end
        check("won_acertou", acertou,   1'b1);
        check("won_pronto",  pronto,    1'b1);
        check("won_errou",   errou,     1'b0);
        check("won_estado",  db_estado, 7'h08);
        check("won_count",   db_contagem, 7'h0E);

        restart();
        check("restart_wait", db_estado, 7'h24);
        for (int i = 0; i < 4; i++) play_move(seq[i], p);
        play_move(4'h1, p);
        check("lost_errou",    errou,       1'b1);
        check("lost_pronto",   pronto,      1'b1);
        check("lost_acertou",  acertou,     1'b0);
        check("lost_contagem", db_contagem, 7'h19);
        check("lost_estado",   db_estado,   7'h06);

        restart();
        for (int i = 0; i < 7; i++) play_move(seq[i], p);
        check("mid_contagem", db_contagem, 7'h78);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("abort_estado",   db_estado,   7'h40);
        check("abort_contagem", db_contagem, 7'h40);
        check("abort_flags",    {acertou, errou, pronto}, 3'b000);
        check("abort_leds",     leds,        4'h0);
        step();
        reset = 1'b1;
        repeat (5) step();
        check("post_abort_idle", db_estado, 7'h40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
